vdac2_video_tx: RTL and testbench

- ZX-Evo FPGA-side transmitter for the VDAC2 video connector.
- Converts the internal 8-bit-per-channel pixel stream into the 5-bit RGB, palette-select and sync bus that the VDAC2 CPLD expands back to 8 bits.
- Owns the bidirectional o_r[0] line. Drives it as red bit 0 in ZX mode. In FT812 mode it releases the line and samples the FT812 interrupt the CPLD returns on it.

---
 rtl/vdac2_video_tx.sv | 197 +++++++++++++++++++
 tb/tb_vdac2_video_tx.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/vdac2_video_tx.sv
`default_nettype none
// ============================================================================
// Module : vdac2_video_tx
// VDAC2 connector transmitter: 8-bit RGB to 5-bit codes plus delayed syncs,
// and turnaround control of the shared r[0] pad for the FT812 interrupt.
// Option : VDAC2_INT_FILTER_EN adds a 3-sample agreement filter on ft_int_n.
// Rev    : 1.0
// ============================================================================
module vdac2_video_tx #(
  parameter int TURN_CYC    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_r,
  input  logic [7:0] in_g,
  input  logic [7:0] in_b,
  input  logic       in_blank,
  input  logic       in_hs,
  input  logic       in_vs,
  input  logic       lin_mode,
  input  logic       ft_sel,
  output logic [4:0] o_r,
  output logic       o_r0_oe,
  input  logic       o_r0_i,
  output logic [4:0] o_g,
  output logic [4:0] o_b,
  output logic       o_hs,
  output logic       o_vs,
  output logic       pal_sel,
  output logic       ft_int_n,
  output logic       ft_int_vld
);

`ifdef VDAC2_INT_FILTER_EN
  localparam int VLD_CYC = SYNC_STAGES + 2;
`else
  localparam int VLD_CYC = SYNC_STAGES;
`endif
  localparam logic [3:0] C_TURN = 4'(TURN_CYC);
  localparam logic [2:0] C_VLD  = 3'(VLD_CYC);

  typedef enum logic [1:0] {
    ST_DRIVE      = 2'd0,
    ST_DRV_TO_REL = 2'd1,
    ST_SAMPLE     = 2'd2,
    ST_REL_TO_DRV = 2'd3
  } state_e;

  function automatic logic [4:0] enc(input logic [7:0] x, input logic lin);
    logic [14:0] prod;
    prod = 15'(x) * 15'd97 + 15'd512;
    enc  = lin ? x[7:3] : prod[14:10];
  endfunction

  logic [7:0] r1_q, r1_d, g1_q, g1_d, b1_q, b1_d;
  logic       hs1_q, hs1_d, vs1_q, vs1_d, lin1_q, lin1_d;
  logic [4:0] r_code_q, r_code_d, g_code_q, g_code_d, b_code_q, b_code_d;
  logic       hs2_q, hs2_d, vs2_q, vs2_d, pal_sel_q, pal_sel_d;

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d, cnt_m1;
  logic [2:0]             vcnt_q, vcnt_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_out, int_w;

  always_comb begin
    r1_d   = in_blank ? 8'd0 : in_r;
    g1_d   = in_blank ? 8'd0 : in_g;
    b1_d   = in_blank ? 8'd0 : in_b;
    hs1_d  = in_hs;
    vs1_d  = in_vs;
    lin1_d = lin_mode;
    // Palette mode switches with the pixel that carries the vsync rise.
    pal_sel_d = (vs1_q && !vs2_q) ? lin1_q : pal_sel_q;
    r_code_d  = enc(r1_q, pal_sel_d);
    g_code_d  = enc(g1_q, pal_sel_d);
    b_code_d  = enc(b1_q, pal_sel_d);
    hs2_d     = hs1_q;
    vs2_d     = vs1_q;
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef VDAC2_INT_FILTER_EN
  logic h1_q, h1_d, h2_q, h2_d, hold_q, hold_d;
  assign int_w = (sync_out == h1_q && h1_q == h2_q) ? sync_out : hold_q;
  always_comb begin
    h1_d   = 1'b1;
    h2_d   = 1'b1;
    hold_d = 1'b1;
    if (state_q == ST_SAMPLE) begin
      h1_d   = sync_out;
      h2_d   = h1_q;
      hold_d = int_w;
    end
  end
`else
  assign int_w = sync_out;
`endif

  always_comb begin
    state_d = state_q;
    cnt_m1  = cnt_q - 4'd1;
    cnt_d   = cnt_m1;
    vcnt_d  = 3'd0;
    sync_d  = '1;
    case (state_q)
      ST_DRIVE: begin
        cnt_d = C_TURN;
        if (ft_sel) state_d = ST_DRV_TO_REL;
      end
      ST_DRV_TO_REL: begin
        if (cnt_m1 == 4'd0) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        sync_d = {sync_q[SYNC_STAGES-2:0], o_r0_i};
        vcnt_d = (vcnt_q == C_VLD) ? vcnt_q : vcnt_q + 3'd1;
        if (!ft_sel) begin
          state_d = ST_REL_TO_DRV;
          cnt_d   = C_TURN;
        end
      end
      default: begin
        // Destination is decided only once the full idle count has run out.
        if (cnt_m1 == 4'd0) begin
          if (ft_sel) begin
            state_d = ST_DRV_TO_REL;
            cnt_d   = C_TURN;
          end else begin
            state_d = ST_DRIVE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_q      <= 8'd0;
      g1_q      <= 8'd0;
      b1_q      <= 8'd0;
      hs1_q     <= 1'b0;
      vs1_q     <= 1'b0;
      lin1_q    <= 1'b0;
      r_code_q  <= 5'd0;
      g_code_q  <= 5'd0;
      b_code_q  <= 5'd0;
      hs2_q     <= 1'b0;
      vs2_q     <= 1'b0;
      pal_sel_q <= 1'b0;
      state_q   <= ST_REL_TO_DRV;
      cnt_q     <= C_TURN;
      vcnt_q    <= 3'd0;
      sync_q    <= '1;
`ifdef VDAC2_INT_FILTER_EN
      h1_q      <= 1'b1;
      h2_q      <= 1'b1;
      hold_q    <= 1'b1;
`endif
    end else begin
      r1_q      <= r1_d;
      g1_q      <= g1_d;
      b1_q      <= b1_d;
      hs1_q     <= hs1_d;
      vs1_q     <= vs1_d;
      lin1_q    <= lin1_d;
      r_code_q  <= r_code_d;
      g_code_q  <= g_code_d;
      b_code_q  <= b_code_d;
      hs2_q     <= hs2_d;
      vs2_q     <= vs2_d;
      pal_sel_q <= pal_sel_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      vcnt_q    <= vcnt_d;
      sync_q    <= sync_d;
`ifdef VDAC2_INT_FILTER_EN
      h1_q      <= h1_d;
      h2_q      <= h2_d;
      hold_q    <= hold_d;
`endif
    end
  end

  assign o_r0_oe    = (state_q == ST_DRIVE);
  assign o_r        = {r_code_q[4:1], r_code_q[0] & o_r0_oe};
  assign o_g        = g_code_q;
  assign o_b        = b_code_q;
  assign o_hs       = hs2_q;
  assign o_vs       = vs2_q;
  assign pal_sel    = pal_sel_q;
  assign ft_int_n   = (state_q == ST_SAMPLE) ? int_w : 1'b1;
  assign ft_int_vld = (state_q == ST_SAMPLE) && (vcnt_q == C_VLD);

endmodule
`default_nettype wire

// File: tb/tb_vdac2_video_tx.sv
`default_nettype none
// ============================================================================
// Module : tb_vdac2_video_tx
// Directed bench for vdac2_video_tx: colour scoreboard plus r[0] bus checks.
// Rev    : 1.0
// ============================================================================
module tb_vdac2_video_tx;

`ifdef VDAC2_INT_FILTER_EN
  localparam int FLT = 2;
`else
  localparam int FLT = 0;
`endif

  logic       clk, rst;
  logic [7:0] in_r, in_g, in_b;
  logic       in_blank, in_hs, in_vs, lin_mode, ft_sel, o_r0_i;
  logic [4:0] o_r, o_g, o_b;
  logic       o_r0_oe, o_hs, o_vs, pal_sel, ft_int_n, ft_int_vld;

  vdac2_video_tx #(.TURN_CYC(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .in_blank(in_blank), .in_hs(in_hs), .in_vs(in_vs), .lin_mode(lin_mode),
    .ft_sel(ft_sel), .o_r(o_r), .o_r0_oe(o_r0_oe), .o_r0_i(o_r0_i),
    .o_g(o_g), .o_b(o_b), .o_hs(o_hs), .o_vs(o_vs), .pal_sel(pal_sel),
    .ft_int_n(ft_int_n), .ft_int_vld(ft_int_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] r, g, b;
    logic       hs, vs, pal;
    logic [7:0] id;
  } exp_t;

  exp_t sb_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   pix_id   = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one pixel, queue its expected codes, advance one clock and
  // retire the pixel that has just reached the outputs.
  task automatic pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                     input logic blank, input logic hs, input logic vs, input logic lin,
                     input logic [4:0] er, input logic [4:0] eg, input logic [4:0] eb,
                     input logic epal);
    exp_t e;
    in_r = r; in_g = g; in_b = b; in_blank = blank;
    in_hs = hs; in_vs = vs; lin_mode = lin;
    e.r = er; e.g = eg; e.b = eb; e.hs = hs; e.vs = vs; e.pal = epal;
    e.id = 8'(pix_id);
    pix_id++;
    sb_q.push_back(e);
    @(posedge clk); #1;
    if (sb_q.size() >= 2) begin
      e = sb_q.pop_front();
      chk($sformatf("pix%0d.r", e.id),   8'(o_r),     8'(e.r));
      chk($sformatf("pix%0d.g", e.id),   8'(o_g),     8'(e.g));
      chk($sformatf("pix%0d.b", e.id),   8'(o_b),     8'(e.b));
      chk($sformatf("pix%0d.hs", e.id),  8'(o_hs),    8'(e.hs));
      chk($sformatf("pix%0d.vs", e.id),  8'(o_vs),    8'(e.vs));
      chk($sformatf("pix%0d.pal", e.id), 8'(pal_sel), 8'(e.pal));
    end
  endtask

  task automatic idle();
    pix(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    sb_q.delete();
    for (int i = 1; i <= 4; i++) begin
      idle();
      chk($sformatf("rel_oe%0d", i), 8'(o_r0_oe), (i == 4) ? 8'd1 : 8'd0);
      chk($sformatf("rel_int%0d", i), 8'(ft_int_n), 8'd1);
      chk($sformatf("rel_vld%0d", i), 8'(ft_int_vld), 8'd0);
    end
  endtask

  initial begin
    rst = 1'b1; in_r = 8'd0; in_g = 8'd0; in_b = 8'd0; in_blank = 1'b0;
    in_hs = 1'b0; in_vs = 1'b0; lin_mode = 1'b0; ft_sel = 1'b0; o_r0_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_oe", 8'(o_r0_oe), 8'd0);
    chk("rst_int", 8'(ft_int_n), 8'd1);
    chk("rst_vld", 8'(ft_int_vld), 8'd0);
    chk("rst_r", 8'(o_r), 8'd0);
    chk("rst_pal", 8'(pal_sel), 8'd0);
    chk("rst_hs", 8'(o_hs), 8'd0);
    release_reset();

    // LUT codes, blanking, sync delay
    pix(8'd0,   8'd255, 8'd10,  1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  5'd24, 5'd1,  1'b0);
    pix(8'd10,  8'd128, 8'd0,   1'b0, 1'b1, 1'b0, 1'b0, 5'd1,  5'd12, 5'd0,  1'b0);
    pix(8'd128, 8'd10,  8'd255, 1'b0, 1'b1, 1'b0, 1'b0, 5'd12, 5'd1,  5'd24, 1'b0);
    pix(8'd255, 8'd0,   8'd128, 1'b0, 1'b0, 1'b0, 1'b0, 5'd24, 5'd0,  5'd12, 1'b0);
    pix(8'd255, 8'd255, 8'd255, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0);
    // lin_mode requested mid-line, takes effect with the vsync rise
    pix(8'd0,   8'hF8,  8'd0,   1'b0, 1'b0, 1'b0, 1'b1, 5'd0,  5'd23, 5'd0,  1'b0);
    pix(8'd0,   8'hF8,  8'd0,   1'b0, 1'b0, 1'b0, 1'b1, 5'd0,  5'd23, 5'd0,  1'b0);
    pix(8'd0,   8'hF8,  8'd0,   1'b0, 1'b0, 1'b1, 1'b1, 5'd0,  5'd31, 5'd0,  1'b1);
    pix(8'd0,   8'hF8,  8'd0,   1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  5'd31, 5'd0,  1'b1);
    pix(8'd128, 8'd0,   8'd255, 1'b0, 1'b0, 1'b0, 1'b0, 5'd16, 5'd0,  5'd31, 1'b1);
    pix(8'd255, 8'd0,   8'd0,   1'b0, 1'b0, 1'b1, 1'b0, 5'd24, 5'd0,  5'd0,  1'b0);
    idle();
    idle();
    idle();

    // Hand the pad to the FT812
    ft_sel = 1'b1;
    idle();
    chk("ft_oe_off", 8'(o_r0_oe), 8'd0);
    for (int i = 1; i <= 6 + FLT; i++) begin
      idle();
      chk($sformatf("ft_vld%0d", i), 8'(ft_int_vld), (i == 6 + FLT) ? 8'd1 : 8'd0);
      chk($sformatf("ft_int%0d", i), 8'(ft_int_n), 8'd1);
      chk($sformatf("ft_oe%0d", i), 8'(o_r0_oe), 8'd0);
    end
    o_r0_i = 1'b0;
    for (int j = 0; j <= 1 + FLT; j++) begin
      idle();
      chk($sformatf("int_low%0d", j), 8'(ft_int_n), (j == 1 + FLT) ? 8'd0 : 8'd1);
    end
    o_r0_i = 1'b1;
    repeat (2 + FLT) idle();
    chk("int_back_hi", 8'(ft_int_n), 8'd1);

`ifdef VDAC2_INT_FILTER_EN
    o_r0_i = 1'b0;
    idle();
    o_r0_i = 1'b1;
    for (int j = 0; j < 6; j++) begin
      idle();
      chk($sformatf("flt_glitch%0d", j), 8'(ft_int_n), 8'd1);
    end
    o_r0_i = 1'b0;
    for (int j = 0; j < 3; j++) begin
      idle();
      chk($sformatf("flt_hold%0d", j), 8'(ft_int_n), 8'd1);
    end
    o_r0_i = 1'b1;
    idle();
    chk("flt_low", 8'(ft_int_n), 8'd0);
    repeat (4) idle();
`else
    o_r0_i = 1'b0;
    idle();
    chk("pulse_pre", 8'(ft_int_n), 8'd1);
    o_r0_i = 1'b1;
    idle();
    chk("pulse_low", 8'(ft_int_n), 8'd0);
    idle();
    chk("pulse_end", 8'(ft_int_n), 8'd1);
`endif

    // Asynchronous reset while sampling a low interrupt
    o_r0_i = 1'b0;
    repeat (5) pix(8'd255, 8'd255, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd24, 5'd24, 5'd0, 1'b0);
    chk("pre_rst_int", 8'(ft_int_n), 8'd0);
    chk("pre_rst_vld", 8'(ft_int_vld), 8'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_oe", 8'(o_r0_oe), 8'd0);
    chk("arst_int", 8'(ft_int_n), 8'd1);
    chk("arst_vld", 8'(ft_int_vld), 8'd0);
    chk("arst_r", 8'(o_r), 8'd0);
    chk("arst_g", 8'(o_g), 8'd0);
    chk("arst_b", 8'(o_b), 8'd0);
    ft_sel = 1'b0;
    o_r0_i = 1'b1;
    release_reset();

    // Two-clock ft_sel pulse during DRIVE: full release then full re-drive wait
    ft_sel = 1'b1;
    idle();
    chk("pulse_oe0", 8'(o_r0_oe), 8'd0);
    idle();
    chk("pulse_oe1", 8'(o_r0_oe), 8'd0);
    ft_sel = 1'b0;
    for (int i = 2; i <= 9; i++) begin
      idle();
      chk($sformatf("pulse_oe%0d", i), 8'(o_r0_oe), (i == 9) ? 8'd1 : 8'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
